// File: rtl/onchip_memory_arbiter_if.sv
// Avalon-MM style requester bundle: one instance per master port.
// The arbiter takes the slave side, the requester takes the master side.
interface onchip_memory_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// Two-master arbiter sharing one single-port 1024x32 RAM, 1-cycle read latency.
// Define ARB_FIXED_PRIORITY_EN for m0-always-wins arbitration (default round-robin).
module onchip_memory_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_memory_arbiter_if.slave m0,
    onchip_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int BE_W = DATA_W / 8;

    logic req0, req1;
    logic g0, g1;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        g0 = req0;
        g1 = req1 & ~req0;
    end
`else
    // last_q high means m1 won the most recent accepted access
    logic last_q, last_d;

    always_comb begin
        g0 = req0;
        g1 = req1;
        if (req0 & req1) begin
            g0 = last_q;
            g1 = ~last_q;
        end
    end

    always_comb begin
        last_d = last_q;
        if (g0 | g1) last_d = g1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b1;
        else          last_q <= last_d;
    end
`endif

    // Idle cycles keep the last address/data on the RAM bus
    always_comb begin
        addr_d = addr_q;
        be_d   = be_q;
        wd_d   = wd_q;
        if (g0) begin
            addr_d = m0.address;
            be_d   = m0.byteenable;
            wd_d   = m0.writedata;
        end else if (g1) begin
            addr_d = m1.address;
            be_d   = m1.byteenable;
            wd_d   = m1.writedata;
        end
    end

    always_comb begin
        rd_pend_d  = (g0 & m0.read & ~m0.write)
                   | (g1 & m1.read & ~m1.write);
        rd_owner_d = rd_owner_q;
        if (g0 | g1) rd_owner_d = g1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wd_q       <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wd_q       <= wd_d;
        end
    end

    assign mem_address    = addr_d;
    assign mem_byteenable = be_d;
    assign mem_writedata  = wd_d;
    assign mem_chipselect = g0 | g1;
    assign mem_write      = (g0 & m0.write) | (g1 & m1.write);
    assign mem_clken      = reset_n;

    assign m0.waitrequest   = req0 & ~g0;
    assign m1.waitrequest   = req1 & ~g1;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rd_pend_q & ~rd_owner_q;
    assign m1.readdatavalid = rd_pend_q & rd_owner_q;
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter with a behavioural 1024x32 RAM.
// Honours ARB_FIXED_PRIORITY_EN when computing expected grant order.
module tb_onchip_memory_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n;
    logic [AW-1:0]   mem_address;
    logic [DW/8-1:0] mem_byteenable;
    logic            mem_chipselect;
    logic            mem_write;
    logic [DW-1:0]   mem_writedata;
    logic            mem_clken;
    logic [DW-1:0]   mem_readdata;
    logic [DW-1:0]   ram [1024];

    int n_cmp = 0;
    int n_err = 0;

    onchip_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    onchip_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    onchip_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m0            (m0_if),
        .m1            (m1_if),
        .mem_address   (mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_clken     (mem_clken),
        .mem_readdata  (mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initv(int a);
        return 32'hA500_0000 | a;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = initv(i);
        mem_readdata = '0;
    end

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic idle();
        m0_if.read = 0; m0_if.write = 0; m0_if.address = '0;
        m0_if.byteenable = '0; m0_if.writedata = '0;
        m1_if.read = 0; m1_if.write = 0; m1_if.address = '0;
        m1_if.byteenable = '0; m1_if.writedata = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wait: got %b%b want 00",
                     m0_if.waitrequest, m1_if.waitrequest);
        end
        n_cmp++;
        if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b%b want 00",
                     m0_if.readdatavalid, m1_if.readdatavalid);
        end
        n_cmp++;
        if ({mem_chipselect, mem_write, mem_clken} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mem: cs/we/clken got %b%b%b want 000",
                     mem_chipselect, mem_write, mem_clken);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (mem_clken !== 1'b1) begin
            n_err++;
            $display("FAIL clken_release: got %b want 1", mem_clken);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        m0_if.write = 1; m0_if.address = 10'd5;
        m0_if.byteenable = 4'hF; m0_if.writedata = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({m0_if.waitrequest, mem_chipselect, mem_write} !== 3'b011
            || mem_address !== 10'd5) begin
            n_err++;
            $display("FAIL wr_accept: wait/cs/we=%b%b%b addr=%0d want 011 addr=5",
                     m0_if.waitrequest, mem_chipselect, mem_write, mem_address);
        end
        cyc();
        idle();
        m1_if.read = 1; m1_if.address = 10'd5;
        #1;
        n_cmp++;
        if (m1_if.waitrequest !== 1'b0 || mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL rd_accept: wait=%b we=%b want 0 0",
                     m1_if.waitrequest, mem_write);
        end
        cyc();
        idle();
        n_cmp++;
        if (m1_if.readdatavalid !== 1'b1 || m0_if.readdatavalid !== 1'b0
            || m1_if.readdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_rd_data: v1=%b v0=%b data=%h want 1 0 deadbeef",
                     m1_if.readdatavalid, m0_if.readdatavalid, m1_if.readdata);
        end
        #1;
        n_cmp++;
        if (mem_chipselect !== 1'b0 || mem_address !== 10'd5) begin
            n_err++;
            $display("FAIL idle_hold: cs=%b addr=%0d want 0 5",
                     mem_chipselect, mem_address);
        end
        cyc();
        n_cmp++;
        if (m1_if.readdatavalid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_once: got %b want 0", m1_if.readdatavalid);
        end
    endtask

    task automatic test_back_to_back();
        int i0 = 0;
        int i1 = 0;
        logic pv = 0;
        logic pown = 0;
        logic [31:0] pdata = '0;
        logic eg1;
        for (int k = 0; k < 9; k++) begin
            if (pv) begin
                n_cmp++;
                if (m0_if.readdatavalid !== !pown
                    || m1_if.readdatavalid !== pown
                    || m0_if.readdata !== pdata) begin
                    n_err++;
                    $display("FAIL b2b_ret k=%0d: v0=%b v1=%b d=%h want %b %b %h",
                             k, m0_if.readdatavalid, m1_if.readdatavalid,
                             m0_if.readdata, !pown, pown, pdata);
                end
            end
            if (k == 8) break;
            m0_if.read = (i0 < 4); m0_if.address = AW'(i0);
            m1_if.read = (i1 < 4); m1_if.address = AW'(100 + i1);
`ifdef ARB_FIXED_PRIORITY_EN
            eg1 = (i0 >= 4);
`else
            eg1 = (k % 2 == 1);
`endif
            #1;
            n_cmp++;
            if (m0_if.waitrequest !== ((i0 < 4) && eg1)
                || m1_if.waitrequest !== ((i1 < 4) && !eg1)) begin
                n_err++;
                $display("FAIL b2b_wait k=%0d: w0=%b w1=%b want %b %b",
                         k, m0_if.waitrequest, m1_if.waitrequest,
                         (i0 < 4) && eg1, (i1 < 4) && !eg1);
            end
            pv = 1; pown = eg1;
            if (eg1) begin pdata = initv(100 + i1); i1++; end
            else     begin pdata = initv(i0);       i0++; end
            cyc();
            idle();
        end
    endtask

    task automatic test_byte_lane();
        m1_if.write = 1; m1_if.address = 10'd5;
        m1_if.byteenable = 4'h1; m1_if.writedata = 32'h000000AA;
        cyc();
        idle();
        m0_if.read = 1; m0_if.address = 10'd5;
        cyc();
        idle();
        n_cmp++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hDEADBEAA) begin
            n_err++;
            $display("FAIL byte_lane: v=%b d=%h want 1 deadbeaa",
                     m0_if.readdatavalid, m0_if.readdata);
        end
    endtask

    task automatic test_read_write_both();
        m0_if.read = 1; m0_if.write = 1; m0_if.address = 10'd7;
        m0_if.byteenable = 4'hF; m0_if.writedata = 32'h12345678;
        #1;
        n_cmp++;
        if (mem_write !== 1'b1 || m0_if.waitrequest !== 1'b0) begin
            n_err++;
            $display("FAIL rw_both_we: we=%b wait=%b want 1 0",
                     mem_write, m0_if.waitrequest);
        end
        cyc();
        idle();
        n_cmp++;
        if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
            n_err++;
            $display("FAIL rw_both_novalid: v0=%b v1=%b want 0 0",
                     m0_if.readdatavalid, m1_if.readdatavalid);
        end
        m0_if.read = 1; m0_if.address = 10'd7;
        cyc();
        idle();
        m1_if.write = 1; m1_if.address = 10'd7;
        m1_if.byteenable = 4'hF; m1_if.writedata = 32'hCAFEF00D;
        n_cmp++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h12345678) begin
            n_err++;
            $display("FAIL rd_before_wr: v=%b d=%h want 1 12345678",
                     m0_if.readdatavalid, m0_if.readdata);
        end
        cyc();
        idle();
        m0_if.read = 1; m0_if.address = 10'd7;
        cyc();
        idle();
        n_cmp++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL wr_after_rd: v=%b d=%h want 1 cafef00d",
                     m0_if.readdatavalid, m0_if.readdata);
        end
    endtask

    task automatic test_reset_mid_read();
        idle();
        m1_if.read = 1; m1_if.address = 10'd101;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        idle();
        @(negedge clk);
        n_cmp++;
        if (m1_if.readdatavalid !== 1'b0 || m0_if.readdatavalid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_valid: v1=%b v0=%b want 0 0",
                     m1_if.readdatavalid, m0_if.readdatavalid);
        end
        n_cmp++;
        if (mem_chipselect !== 1'b0 || mem_clken !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_mem: cs=%b clken=%b want 0 0",
                     mem_chipselect, mem_clken);
        end
        reset_n = 1'b1;
        m0_if.read = 1; m0_if.address = 10'd2;
        m1_if.read = 1; m1_if.address = 10'd102;
        #1;
        n_cmp++;
        if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1
            || mem_address !== 10'd2) begin
            n_err++;
            $display("FAIL post_rst_grant: w0=%b w1=%b addr=%0d want 0 1 2",
                     m0_if.waitrequest, m1_if.waitrequest, mem_address);
        end
        cyc();
        m0_if.read = 0;
        n_cmp++;
        if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0
            || m0_if.readdata !== initv(2)) begin
            n_err++;
            $display("FAIL post_rst_m0: v0=%b v1=%b d=%h want 1 0 %h",
                     m0_if.readdatavalid, m1_if.readdatavalid,
                     m0_if.readdata, initv(2));
        end
        #1;
        n_cmp++;
        if (m1_if.waitrequest !== 1'b0 || m0_if.waitrequest !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst_m1_wait: w1=%b w0=%b want 0 0",
                     m1_if.waitrequest, m0_if.waitrequest);
        end
        cyc();
        idle();
        n_cmp++;
        if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== initv(102)) begin
            n_err++;
            $display("FAIL post_rst_m1: v=%b d=%h want 1 %h",
                     m1_if.readdatavalid, m1_if.readdata, initv(102));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_byte_lane();
        test_read_write_both();
        test_reset_mid_read();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onchip_memory_arbiter.md
# onchip_memory_arbiter

Two-master arbiter in front of the single-port 1024×32 on-chip RAM. It shares the one RAM port between two Avalon-MM style requesters (CPU data master m0, DMA/auxiliary master m1), issues at most one access per cycle, and returns read data with a fixed one-cycle latency. Read data is routed back to the master that issued the read.

## Interface
Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- mN_address  in  ADDR_W  word address, N = 0, 1
- mN_byteenable  in  DATA_W/8  write byte lanes
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high means the request was not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata valid this cycle
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; equals reset_n
- mem_readdata  in  DATA_W  from RAM, valid the cycle after the address edge

## Operation
- reqN = mN_read | mN_write. If both are high on one master, the write wins and no read data is returned.
- Grant is combinational each cycle: exactly one of g0/g1, or none. An access is accepted in the cycle its grant is high.
- Arbitration: a single requester is always granted. When both request, the master that was not granted most recently wins.
- last_grant register: updates to the winner on every accepted access; it resets to 1, so m0 wins the first contention.
- mN_waitrequest = reqN & ~gN. It is combinational, and a non-requesting master sees 0.
- Memory drive: mem_* copies the granted master's address, byteenable and writedata. mem_chipselect = g0|g1. mem_write = the granted master's write. With no grant: chipselect=0, write=0, address/data hold their last values.
- Read tracking registers: rd_pend and rd_owner. rd_pend <= granted & read & ~write; rd_owner <= winner.
- Return path: mN_readdatavalid = rd_pend & (rd_owner==N). mN_readdata = mem_readdata, driven to both ports; only the valid strobe qualifies it.
- Writes produce no response.

## Timing
- Reset values: rd_pend=0 and last_grant=1; all valids 0; mem_chipselect=0, mem_write=0, mem_clken=0. Waitrequest is 0 while nothing is requested.
- Read latency: accept in cycle T → mN_readdatavalid high in cycle T+1 only. Throughput is one access per cycle total.
- Back-to-back reads from alternating masters: the valids alternate with no bubbles.
- Read then write to the same address on consecutive cycles: the read returns the old data.
- Reset asserted mid-read: rd_pend clears asynchronously, so the pending valid never appears. After release, the first contention goes to m0.
- A master that drops its request while waiting loses nothing; the arbiter holds no state for it.

## Configuration
- ARB_FIXED_PRIORITY_EN
  - Defined: m0 always wins contention; last_grant is not used (it may be optimised away). m1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, no requests → all waitrequest=0, all valids=0, mem_chipselect=0, mem_clken=0 until reset_n rises.
- m0 writes 0xDEADBEEF, byteenable 0xF, to address 5; m1 then reads address 5 → m1_readdatavalid one cycle after accept, m1_readdata=0xDEADBEEF, m0_readdatavalid stays 0.
- Both masters read continuously (m0 addresses 0..3, m1 addresses 100..103) → grants m0,m1,m0,m1,…, each waitrequest high on alternate cycles. With ARB_FIXED_PRIORITY_EN, m0 completes all 4 before m1 is granted.
- Byte-lane write of 0x000000AA with byteenable 0x1 over 0xDEADBEEF → a following read returns 0xDEADBEAA.
- m0 asserts read and write together to address 7 with 0x12345678 → memory written, no m0_readdatavalid.
- m1 read accepted, reset_n pulled low the next half-cycle → m1_readdatavalid never asserts. After release, simultaneous requests grant m0 first.
